// File: rtl/retire_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : retire_commit_queue
// Brief    : In-order buffer between the ROB retire ports and the PRF/free list.
//            Accepts up to two packets per cycle and drains one per cycle.
//            Optional macro COMMIT_STATS_EN adds stall_cnt and fl_wait_cnt.
// Revision : 1.0  initial release
// ============================================================================
module retire_commit_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret0_valid,
  input  logic [PREG_W-1:0]        ret0_rd,
  input  logic [DATA_W-1:0]        ret0_data,
  input  logic [PREG_W-1:0]        ret0_old_rd,
  input  logic                     ret1_valid,
  input  logic [PREG_W-1:0]        ret1_rd,
  input  logic [DATA_W-1:0]        ret1_data,
  input  logic [PREG_W-1:0]        ret1_old_rd,
  output logic                     ret_ready,
  output logic                     rf_we,
  output logic [PREG_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     fl_valid,
  output logic [PREG_W-1:0]        fl_preg,
  input  logic                     fl_ready,
`ifdef COMMIT_STATS_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              fl_wait_cnt,
`endif
  output logic [31:0]              commit_cnt,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [PREG_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PREG_W-1:0] old_mem  [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic          enq0;
  logic          enq1;
  logic [1:0]    enq_n;
  logic [AW-1:0] slot1;
  logic          not_empty;
  logic          need_rf;
  logic          need_fl;
  logic          drain;

  // Readiness looks only at the registered count; a same-cycle drain is never credited.
  assign ret_ready = (count <= READY_MAX);
  assign enq0      = ret_ready & ret0_valid;
  assign enq1      = ret_ready & ret1_valid;
  assign enq_n     = {1'b0, enq0} + {1'b0, enq1};
  assign slot1     = tail + AW'(enq0);

  assign not_empty = (count != '0);
  assign need_rf   = (rd_mem[head] != '0);
  assign need_fl   = (old_mem[head] != '0);
  assign drain     = not_empty & (~need_fl | fl_ready);

  assign fl_valid  = not_empty & need_fl;
  assign fl_preg   = old_mem[head];
  assign rf_we     = drain & need_rf;
  assign rf_waddr  = rd_mem[head];
  assign rf_wdata  = data_mem[head];
  assign q_count   = count;

  always_ff @(posedge clk) begin
    if (enq0) begin
      rd_mem[tail]   <= ret0_rd;
      data_mem[tail] <= ret0_data;
      old_mem[tail]  <= ret0_old_rd;
    end
    if (enq1) begin
      rd_mem[slot1]   <= ret1_rd;
      data_mem[slot1] <= ret1_data;
      old_mem[slot1]  <= ret1_old_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      commit_cnt <= '0;
    end else begin
      tail  <= tail + AW'(enq_n);
      count <= count + (AW+1)'(enq_n) - (AW+1)'(drain);
      if (drain) begin
        head       <= head + 1'b1;
        commit_cnt <= commit_cnt + 32'd1;
      end
    end
  end

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      fl_wait_cnt <= '0;
    end else begin
      if ((ret0_valid | ret1_valid) & ~ret_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (fl_valid & ~fl_ready)
        fl_wait_cnt <= fl_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_commit_queue
// Brief    : Directed self-checking bench for retire_commit_queue (DEPTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_retire_commit_queue;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ret0_valid = 1'b0;
  logic [PREG_W-1:0] ret0_rd = '0;
  logic [DATA_W-1:0] ret0_data = '0;
  logic [PREG_W-1:0] ret0_old_rd = '0;
  logic              ret1_valid = 1'b0;
  logic [PREG_W-1:0] ret1_rd = '0;
  logic [DATA_W-1:0] ret1_data = '0;
  logic [PREG_W-1:0] ret1_old_rd = '0;
  logic              ret_ready;
  logic              rf_we;
  logic [PREG_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fl_valid;
  logic [PREG_W-1:0] fl_preg;
  logic              fl_ready = 1'b1;
  logic [31:0]       commit_cnt;
  logic [3:0]        q_count;
`ifdef COMMIT_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       fl_wait_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  retire_commit_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ret0_valid(ret0_valid), .ret0_rd(ret0_rd), .ret0_data(ret0_data), .ret0_old_rd(ret0_old_rd),
    .ret1_valid(ret1_valid), .ret1_rd(ret1_rd), .ret1_data(ret1_data), .ret1_old_rd(ret1_old_rd),
    .ret_ready(ret_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fl_valid(fl_valid), .fl_preg(fl_preg), .fl_ready(fl_ready),
`ifdef COMMIT_STATS_EN
    .stall_cnt(stall_cnt), .fl_wait_cnt(fl_wait_cnt),
`endif
    .commit_cnt(commit_cnt), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks follow at +2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input int rd, input int data, input int old);
    ret0_valid = v; ret0_rd = PREG_W'(rd); ret0_data = DATA_W'(data); ret0_old_rd = PREG_W'(old);
  endtask

  task automatic set1(input logic v, input int rd, input int data, input int old);
    ret1_valid = v; ret1_rd = PREG_W'(rd); ret1_data = DATA_W'(data); ret1_old_rd = PREG_W'(old);
  endtask

  task automatic idle();
    ret0_valid = 1'b0;
    ret1_valid = 1'b0;
  endtask

  initial begin
    // ---- reset state
    cyc(); cyc();
    #1;
    chk("rst_q_count", q_count, 0);
    chk("rst_ret_ready", ret_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_fl_valid", fl_valid, 0);
    chk("rst_commit", commit_cnt, 0);
    rst = 1'b0;

    // ---- single retire
    cyc();
    set0(1, 5, 42, 3);
    #1 chk("single_pre_rf_we", rf_we, 0);
    cyc(); idle();
    #1;
    chk("single_q", q_count, 1);
    chk("single_rf_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 42);
    chk("single_fl_valid", fl_valid, 1);
    chk("single_fl_preg", fl_preg, 3);
    cyc();
    #1;
    chk("single_commit", commit_cnt, 1);
    chk("single_q_after", q_count, 0);
    chk("single_rf_we_after", rf_we, 0);

    // ---- dual retire
    set0(1, 7, 10, 1); set1(1, 8, 20, 2);
    cyc(); idle();
    #1;
    chk("dual_q", q_count, 2);
    chk("dual_waddr0", rf_waddr, 7);
    chk("dual_wdata0", rf_wdata, 10);
    chk("dual_fl_preg0", fl_preg, 1);
    cyc();
    #1;
    chk("dual_rf_we1", rf_we, 1);
    chk("dual_waddr1", rf_waddr, 8);
    chk("dual_wdata1", rf_wdata, 20);
    chk("dual_fl_preg1", fl_preg, 2);
    cyc();
    #1;
    chk("dual_q_after", q_count, 0);
    chk("dual_commit", commit_cnt, 3);

    // ---- zero registers: no strobes but still drains
    set0(1, 0, 9, 0);
    cyc(); idle();
    #1;
    chk("zero_q", q_count, 1);
    chk("zero_rf_we", rf_we, 0);
    chk("zero_fl_valid", fl_valid, 0);
    cyc();
    #1;
    chk("zero_q_after", q_count, 0);
    chk("zero_commit", commit_cnt, 4);

    // ---- free-list stall fills the queue
    fl_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set0(1, 10 + 2*k, 100 + 2*k, 20 + 2*k);
      set1(1, 11 + 2*k, 101 + 2*k, 21 + 2*k);
      #1;
      chk("stall_ready", ret_ready, 1);
      chk("stall_rf_we", rf_we, 0);
      cyc();
    end
    set0(1, 63, 999, 62); set1(1, 63, 998, 61);
    #1;
    chk("full_q", q_count, 8);
    chk("full_ready", ret_ready, 0);
    chk("full_rf_we", rf_we, 0);
    chk("full_fl_valid", fl_valid, 1);
    chk("full_fl_preg", fl_preg, 20);
    cyc(); idle();
    #1;
    chk("full_ignore_q", q_count, 8);
    chk("full_hold_preg", fl_preg, 20);
    fl_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_rf_we", rf_we, 1);
      chk("drain_waddr", rf_waddr, 10 + i);
      chk("drain_wdata", rf_wdata, 100 + i);
      chk("drain_fl_preg", fl_preg, 20 + i);
      cyc();
      if (i == 0) begin
        #1;
        chk("drain_q7", q_count, 7);
        chk("drain_ready7", ret_ready, 0);
      end
    end
    #1;
    chk("drain_q_after", q_count, 0);
    chk("drain_commit", commit_cnt, 12);

    // ---- pointer wrap: tail walks 4 -> 7, then a pair lands in slots 7 and 0
    set0(1, 31, 301, 11);
    cyc();
    set0(0, 0, 0, 0); set1(1, 32, 302, 12);
    #1 chk("wrap_head31", rf_waddr, 31);
    cyc();
    set1(0, 0, 0, 0); set0(1, 33, 303, 13);
    #1;
    chk("wrap_head32", rf_waddr, 32);
    chk("wrap_q1", q_count, 1);
    cyc();
    set0(1, 40, 400, 4); set1(1, 41, 401, 5);
    #1 chk("wrap_head33", rf_waddr, 33);
    cyc(); idle();
    #1;
    chk("wrap_q2", q_count, 2);
    chk("wrap_waddr7", rf_waddr, 40);
    chk("wrap_wdata7", rf_wdata, 400);
    cyc();
    #1;
    chk("wrap_waddr0", rf_waddr, 41);
    chk("wrap_wdata0", rf_wdata, 401);
    chk("wrap_fl_preg0", fl_preg, 5);
    cyc();
    #1;
    chk("wrap_q_after", q_count, 0);
    chk("wrap_commit", commit_cnt, 17);

    // ---- reset in the middle of a drain
    fl_ready = 1'b0;
    set0(1, 50, 500, 30); set1(1, 51, 501, 31);
    cyc(); cyc();
    set1(0, 0, 0, 0); set0(1, 54, 504, 34);
    cyc(); idle();
    #1;
    chk("mid_q5", q_count, 5);
    fl_ready = 1'b1;
    #1 chk("mid_rf_we_on", rf_we, 1);
    rst = 1'b1;
    #1;
    chk("mid_rf_we_off", rf_we, 0);
    chk("mid_fl_valid_off", fl_valid, 0);
    chk("mid_q0", q_count, 0);
    chk("mid_commit0", commit_cnt, 0);
    chk("mid_ready", ret_ready, 1);
    cyc();
    #1 chk("mid_rf_we_held", rf_we, 0);
    rst = 1'b0;

    // ---- queue works again after reset
    set0(1, 3, 77, 0);
    cyc(); idle();
    #1;
    chk("post_rf_we", rf_we, 1);
    chk("post_fl_valid", fl_valid, 0);
    chk("post_wdata", rf_wdata, 77);
    cyc();
    #1 chk("post_commit", commit_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/retire_commit_queue.md
Name: retire_commit_queue

Overview:
- Sits directly downstream of the ROB retire ports, which deliver up to two retire packets per cycle carrying rd, data and old_rd.
- Buffers retired packets in order, in a small circular queue.
- Drains one packet per cycle. Each drain writes the physical register file and releases old_rd to the free list under a ready handshake.
- Exposes a committed-instruction counter for the testbench and for performance checks.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- PREG_W, 6, physical register index width.
- DATA_W, 32, result data width.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ret0_valid  input  1  retire slot 0 valid (older)
- ret0_rd  input  PREG_W  destination physical register
- ret0_data  input  DATA_W  result value
- ret0_old_rd  input  PREG_W  previous mapping, to be freed
- ret1_valid  input  1  retire slot 1 valid (younger)
- ret1_rd  input  PREG_W  destination physical register
- ret1_data  input  DATA_W  result value
- ret1_old_rd  input  PREG_W  previous mapping, to be freed
- ret_ready  output  1  queue can accept two packets this cycle
- rf_we  output  1  register file write strobe
- rf_waddr  output  PREG_W  write address
- rf_wdata  output  DATA_W  write data
- fl_valid  output  1  free-list release request
- fl_preg  output  PREG_W  register being released
- fl_ready  input  1  free list accepts the release
- commit_cnt  output  32  total drained packets
- q_count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - head, tail and q_count = 0; commit_cnt = 0.
  - ret_ready = 1; rf_we = 0; fl_valid = 0.
  - Entries held at reset are discarded. A reset asserted mid-drain must not produce an rf_we pulse.
- ret_ready = (DEPTH - q_count) >= 2. It is computed from the registered count only; the same-cycle drain is never credited.
- Enqueue happens at the clock edge when ret_ready = 1:
  - If ret0_valid, ret0 is written at tail.
  - If ret1_valid, ret1 is written at tail+ret0_valid.
  - tail advances by ret0_valid + ret1_valid (0, 1 or 2), modulo DEPTH.
  - ret1 alone (ret0_valid = 0) is legal and takes one slot.
  - Any valid packet presented while ret_ready = 0 is ignored; the ROB must hold it.
- Head entry and drain condition:
  - need_rf = (rd != 0).
  - need_fl = (old_rd != 0); register 0 is never freed.
  - drain = (q_count != 0) & (!need_fl | fl_ready).
- Output timing:
  - fl_valid = (q_count != 0) & need_fl, driven combinationally from the head entry.
  - fl_preg = head old_rd.
  - rf_we = drain & need_rf; rf_waddr and rf_wdata come from the head entry.
  - rf_we and fl_valid must both be 0 whenever q_count = 0.
- Drain effect at the edge: head advances by 1 (mod DEPTH) and commit_cnt increments by 1, wrapping at 2^32.
- Minimum latency: a packet enqueued at edge N drives rf_we in cycle N+1 at the earliest.
- Simultaneous enqueue and drain: q_count_next = q_count + enq_n - drain, where enq_n is 0 to 2.
- Back-pressure: while fl_ready = 0, the head stays put and is presented unchanged every cycle (no duplicate rf_we), and the queue fills. ret_ready falls once q_count ≥ DEPTH-1.
- Pointer wrap: a packet pair straddling the DEPTH-1 to 0 boundary is stored contiguously and mod-correctly.
- Ordering: drain order equals retire order (ret0 before ret1, older cycles first). No reordering under any stall pattern.

Optional Feature:
- Macro: COMMIT_STATS_EN.
- Defined:
  - Adds output stall_cnt [31:0], which increments each cycle in which (ret0_valid | ret1_valid) & !ret_ready.
  - Adds output fl_wait_cnt [31:0], which increments each cycle in which fl_valid & !fl_ready.
  - Both counters reset to 0 and wrap.
- Undefined: neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Single retire: ret0 = {rd=5, data=42, old_rd=3}, fl_ready = 1 -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 42, fl_valid = 1, fl_preg = 3; commit_cnt = 1; q_count returns to 0.
- Dual retire: ret0 = {7, 10, 1} and ret1 = {8, 20, 2} in one cycle -> two consecutive drain cycles, rd 7 then rd 8; commit_cnt = 2.
- Zero registers: packet {rd=0, data=9, old_rd=0} -> no rf_we, no fl_valid; it still drains and commit_cnt increments.
- Free-list stall: hold fl_ready = 0 and retire 2 packets per cycle from empty, DEPTH = 8 -> ret_ready drops after 4 accepted cycles (q_count = 8); no rf_we while stalled. Release fl_ready -> 8 drains in order.
- Wrap: interleave enqueue/drain until tail = 7, then retire a pair -> entries land in slots 7 and 0 and drain in correct order.
- Reset mid-drain: assert rst asynchronously with q_count = 5 -> rf_we and fl_valid drop immediately; q_count = 0, commit_cnt = 0, ret_ready = 1.
